// File: rtl/bip_control_if.sv
// rtl/bip_control_if.sv - BIP control unit bundle: program memory, datapath strobes, debug
interface bip_control_if #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  logic               EN;
  logic [INSTR_W-1:0] INSTR;
  logic [ADDR_W-1:0]  PC_ADDR;
  logic [ADDR_W-1:0]  OPERAND;
  logic [1:0]         SEL_A;
  logic               SEL_B;
  logic               OP;
  logic               WR_ACC;
  logic               WR_RAM;
  logic               RD_RAM;
  logic               HALTED;
  logic [CNT_W-1:0]   CYCLE_COUNT;

  // Control unit side
  modport master (
    input  EN, INSTR,
    output PC_ADDR, OPERAND, SEL_A, SEL_B, OP, WR_ACC, WR_RAM, RD_RAM, HALTED, CYCLE_COUNT
  );

  // Memory / datapath / debug side
  modport slave (
    output EN, INSTR,
    input  PC_ADDR, OPERAND, SEL_A, SEL_B, OP, WR_ACC, WR_RAM, RD_RAM, HALTED, CYCLE_COUNT
  );
endinterface

// File: rtl/bip_control.sv
// rtl/bip_control.sv - BIP instruction fetch, decode and control unit
module bip_control #(
  parameter int ADDR_W  = 11,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  bip_control_if.master bus
);

  localparam int OPC_W = INSTR_W - ADDR_W;

  localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               halted;

  logic [OPC_W-1:0]   opcode;
  logic [ADDR_W-1:0]  operand;
  logic [1:0]         sel_a;
  logic               sel_b;
  logic               op;
  logic               wr_acc;
  logic               wr_ram;
  logic               rd_ram;

  assign opcode = bus.INSTR[INSTR_W-1:ADDR_W];

  // State, PC, cycle counter and halt flag; RESET clears everything without waiting for an edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= FETCH;
      pc     <= '0;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      cnt    <= cnt_nxt;
      halted <= (state_nxt == HALT);
    end
  end

  // Next-state, PC advance, saturating counter and EN-gated decode strobes
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    operand   = '0;
    sel_a     = 2'd0;
    sel_b     = 1'b0;
    op        = 1'b0;
    wr_acc    = 1'b0;
    wr_ram    = 1'b0;
    rd_ram    = 1'b0;

    // Counter sticks at all-ones rather than wrapping
    if (bus.EN && (state != HALT) && (cnt != {CNT_W{1'b1}}))
      cnt_nxt = cnt + 1'b1;

    case (state)
      FETCH: begin
        if (bus.EN)
          state_nxt = EXEC;
      end
      EXEC: begin
        operand = bus.INSTR[ADDR_W-1:0];
        if (bus.EN) begin
          case (opcode)
            OPC_STO: wr_ram = 1'b1;
            OPC_LD: begin
              sel_a  = 2'd0;
              wr_acc = 1'b1;
              rd_ram = 1'b1;
            end
            OPC_LDI: begin
              sel_a  = 2'd1;
              wr_acc = 1'b1;
            end
            OPC_ADD, OPC_SUB: begin
              sel_a  = 2'd2;
              sel_b  = 1'b0;
              op     = (opcode == OPC_SUB);
              wr_acc = 1'b1;
              rd_ram = 1'b1;
            end
            OPC_ADDI, OPC_SUBI: begin
              sel_a  = 2'd2;
              sel_b  = 1'b1;
              op     = (opcode == OPC_SUBI);
              wr_acc = 1'b1;
            end
            default: ;
          endcase
          // HLT leaves PC pointing at itself; everything else (including NOPs) advances
          if (opcode == OPC_HLT) begin
            state_nxt = HALT;
          end else begin
            pc_nxt    = pc + 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  assign bus.PC_ADDR     = pc;
  assign bus.OPERAND     = operand;
  assign bus.SEL_A       = sel_a;
  assign bus.SEL_B       = sel_b;
  assign bus.OP          = op;
  assign bus.WR_ACC      = wr_acc;
  assign bus.WR_RAM      = wr_ram;
  assign bus.RD_RAM      = rd_ram;
  assign bus.HALTED      = halted;
  assign bus.CYCLE_COUNT = cnt;

endmodule

// File: tb/tb_bip_control.sv
// tb/tb_bip_control.sv - scoreboard bench for bip_control with a cycle-level reference model
module tb_bip_control;

  logic clk;
  logic rst;

  bip_control_if bus ();

  bip_control dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory: registered read, one cycle after the address
  logic [15:0] mem [0:2047];
  always @(posedge clk) bus.INSTR <= mem[bus.PC_ADDR];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_phase;  // 0 fetch, 1 exec, 2 halted
  int m_pc;
  int m_cnt;
  logic prev_rst;
  logic prev_en;

  logic [45:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram} for each opcode
  function automatic logic [6:0] decode(input int opc);
    case (opc)
      1:       return 7'b00_0_0_0_1_0;
      2:       return 7'b00_0_0_1_0_1;
      3:       return 7'b01_0_0_1_0_0;
      4:       return 7'b10_0_0_1_0_1;
      5:       return 7'b10_1_0_1_0_0;
      6:       return 7'b10_0_1_1_0_1;
      7:       return 7'b10_1_1_1_0_0;
      default: return 7'b0;
    endcase
  endfunction

  function automatic logic [45:0] expect_vec(input logic e);
    logic [15:0] w;
    logic [10:0] opnd;
    logic [6:0]  d;
    logic [10:0] pc11;
    logic [15:0] cnt16;
    w     = mem[m_pc];
    opnd  = 11'd0;
    d     = 7'd0;
    pc11  = 11'(m_pc);
    cnt16 = 16'(m_cnt);
    if (m_phase == 1) begin
      opnd = w[10:0];
      if (e) d = decode(int'(w[15:11]));
    end
    return {(m_phase == 2), pc11, cnt16, opnd, d};
  endfunction

  function automatic logic [45:0] actual_vec();
    return {bus.HALTED, bus.PC_ADDR, bus.CYCLE_COUNT, bus.OPERAND,
            bus.SEL_A, bus.SEL_B, bus.OP, bus.WR_ACC, bus.WR_RAM, bus.RD_RAM};
  endfunction

  task automatic model_advance();
    if (m_phase != 2 && m_cnt < 65535) m_cnt++;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (mem[m_pc][15:11] == 5'd0) m_phase = 2;
      else begin
        m_pc    = (m_pc + 1) % 2048;
        m_phase = 0;
      end
    end
  endtask

  // One clock cycle: retire the previous edge in the model, then drive and predict this cycle
  task automatic step(input logic r, input logic e);
    @(posedge clk);
    if (!prev_rst && prev_en) model_advance();
    #1;
    rst    = r;
    bus.EN = e;
    if (r) begin
      m_phase = 0;
      m_pc    = 0;
      m_cnt   = 0;
    end
    exp_q.push_back(expect_vec(e));
    prev_rst = r;
    prev_en  = e;
  endtask

  function automatic logic [15:0] ins(input int opc, input int opnd);
    logic [4:0]  o;
    logic [10:0] a;
    o = 5'(opc);
    a = 11'(opnd);
    return {o, a};
  endfunction

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 2048; i++) mem[i] = w;
  endtask

  task automatic load_prog1();
    fill(16'h4000);
    mem[0] = ins(3, 16);
    mem[1] = ins(1, 1);
    mem[2] = ins(2, 1);
    mem[3] = ins(5, 255);
    mem[4] = ins(1, 2);
    mem[5] = ins(2, 2);
    mem[6] = ins(0, 0);
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it against the queued prediction
  initial begin
    int cyc;
    logic [45:0] e;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("sb_cycle%0d", cyc), 64'(actual_vec()), 64'(e));
        cyc++;
      end
    end
  end

  initial begin
    int wr_cnt;
    rst      = 1'b1;
    bus.EN   = 1'b0;
    prev_rst = 1'b1;
    prev_en  = 1'b0;
    m_phase  = 0;
    m_pc     = 0;
    m_cnt    = 0;
    load_prog1();

    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("reset_pc", 64'(bus.PC_ADDR), 64'd0);
    chk("reset_halted", 64'(bus.HALTED), 64'd0);

    // Program 1 from reset with EN high
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b1);
      @(negedge clk);
      if (c == 1) begin
        chk("p1_c1_wr_acc", 64'(bus.WR_ACC), 64'd1);
        chk("p1_c1_sel_a", 64'(bus.SEL_A), 64'd1);
        chk("p1_c1_operand", 64'(bus.OPERAND), 64'd16);
      end
      if (c == 3) begin
        chk("p1_c3_wr_ram", 64'(bus.WR_RAM), 64'd1);
        chk("p1_c3_operand", 64'(bus.OPERAND), 64'd1);
      end
      if (c == 7)
        chk("p1_c7_alu", 64'({bus.SEL_A, bus.SEL_B, bus.OP, bus.OPERAND}), 64'({2'd2, 1'b1, 1'b0, 11'd255}));
      if (c >= 14) begin
        chk("p1_halted", 64'(bus.HALTED), 64'd1);
        chk("p1_halt_pc", 64'(bus.PC_ADDR), 64'd6);
        chk("p1_halt_cnt", 64'(bus.CYCLE_COUNT), 64'd14);
      end
    end

    // Reset pulse while halted, then reset pulse in the EXEC of instruction 2
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("rst_halt_halted", 64'(bus.HALTED), 64'd0);
    chk("rst_halt_cnt", 64'(bus.CYCLE_COUNT), 64'd0);
    for (int c = 0; c < 24; c++) begin
      step(c == 5, 1'b1);
      @(negedge clk);
      if (c == 5) begin
        chk("rst_exec_wr_acc", 64'(bus.WR_ACC), 64'd0);
        chk("rst_exec_pc", 64'(bus.PC_ADDR), 64'd0);
      end
    end

    // Program 2: SUB/SUBI, opcode 01010 at PC 4, LDI at PC 5 with EN dropped during its EXEC
    step(1'b1, 1'b1);
    fill(16'h4000);
    mem[0] = ins(6, 3);
    mem[1] = ins(7, 5);
    mem[4] = ins(10, 9);
    mem[5] = ins(3, 7);
    mem[6] = ins(0, 0);
    wr_cnt = 0;
    for (int c = 0; c < 22; c++) begin
      step(1'b0, !(c >= 11 && c < 16));
      @(negedge clk);
      if (c == 1) chk("sub_ctl", 64'({bus.OP, bus.RD_RAM, bus.SEL_B}), 64'({1'b1, 1'b1, 1'b0}));
      if (c == 3) chk("subi_ctl", 64'({bus.OP, bus.RD_RAM, bus.SEL_B}), 64'({1'b1, 1'b0, 1'b1}));
      if (c == 9) chk("nop_strobes", 64'({bus.WR_ACC, bus.WR_RAM, bus.RD_RAM}), 64'd0);
      if (c == 10) chk("nop_pc_next", 64'(bus.PC_ADDR), 64'd5);
      if (c >= 11 && c < 16) chk("en_low_cnt", 64'(bus.CYCLE_COUNT), 64'd11);
      if (c >= 11 && c < 18 && bus.WR_ACC) wr_cnt++;
    end
    chk("ldi_wr_acc_pulses", 64'(wr_cnt), 64'd1);

    // Random programs, random EN and occasional RESET pulses
    step(1'b1, 1'b1);
    for (int i = 0; i < 2048; i++) begin
      int opc;
      opc = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 31));
      mem[i] = ins(opc, int'($urandom_range(0, 2047)));
    end
    for (int c = 0; c < 4000; c++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8);

    // NOP-filled memory: PC wraps past 2047 repeatedly and the counter saturates
    step(1'b1, 1'b1);
    fill(16'h4000);
    for (int c = 0; c < 66000; c++) step(1'b0, 1'b1);
    @(negedge clk);
    chk("cnt_saturated", 64'(bus.CYCLE_COUNT), 64'hFFFF);
    chk("nop_not_halted", 64'(bus.HALTED), 64'd0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
